// File: rtl/countdown_timer_hms.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_hms
// Loadable HH:MM:SS down-counter with start/pause control and expiry flag.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer_hms #(
  parameter int TICK_DIV = 1,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HR_MAX   = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hr,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] count_sec,
  output logic [5:0] count_min,
  output logic [4:0] count_hr,
  output logic       borrow_sec,
  output logic       borrow_min,
  output logic       done,
  output logic       expired,
  output logic       running
);

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [5:0]      SEC_TOP  = 6'(SEC_MAX);
  localparam logic [5:0]      MIN_TOP  = 6'(MIN_MAX);
  localparam logic [4:0]      HR_TOP   = 5'(HR_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [5:0]       w_sec_nxt;
  logic [5:0]       w_min_nxt;
  logic [4:0]       w_hr_nxt;
  logic             w_bsec_nxt;
  logic             w_bmin_nxt;
  logic             w_done_nxt;
  logic             w_nonzero;

  assign w_nonzero = (count_sec != 6'd0) || (count_min != 6'd0) || (count_hr != 5'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_sec_nxt   = count_sec;
    w_min_nxt   = count_min;
    w_hr_nxt    = count_hr;
    w_bsec_nxt  = 1'b0;
    w_bmin_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    if (load) begin
      w_state_nxt = ST_IDLE;
      w_div_nxt   = '0;
      w_sec_nxt   = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;
      w_min_nxt   = (load_min > MIN_TOP) ? MIN_TOP : load_min;
      w_hr_nxt    = (load_hr  > HR_TOP)  ? HR_TOP  : load_hr;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Starting from 00:00:00 is a no-op rather than an instant expiry
          if (!pause && start && w_nonzero) begin
            w_state_nxt = ST_RUN;
            w_div_nxt   = '0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_div == DIV_LAST) begin
            w_div_nxt = '0;
            if (count_sec != 6'd0) begin
              w_sec_nxt = count_sec - 6'd1;
            end else if (count_min != 6'd0) begin
              w_sec_nxt  = SEC_TOP;
              w_min_nxt  = count_min - 6'd1;
              w_bsec_nxt = 1'b1;
            end else if (count_hr != 5'd0) begin
              w_sec_nxt  = SEC_TOP;
              w_min_nxt  = MIN_TOP;
              w_hr_nxt   = count_hr - 5'd1;
              w_bsec_nxt = 1'b1;
              w_bmin_nxt = 1'b1;
            end
            if ((w_sec_nxt == 6'd0) && (w_min_nxt == 6'd0) && (w_hr_nxt == 5'd0)) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_div_nxt = r_div + DIV_W'(1);
          end
        end
        ST_PAUSE: begin
          // Divider keeps its held phase so the partial second is not lost
          if (!pause && start) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      count_sec  <= 6'd0;
      count_min  <= 6'd0;
      count_hr   <= 5'd0;
      borrow_sec <= 1'b0;
      borrow_min <= 1'b0;
      done       <= 1'b0;
      expired    <= 1'b0;
      running    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      count_sec  <= w_sec_nxt;
      count_min  <= w_min_nxt;
      count_hr   <= w_hr_nxt;
      borrow_sec <= w_bsec_nxt;
      borrow_min <= w_bmin_nxt;
      done       <= w_done_nxt;
      expired    <= (w_state_nxt == ST_DONE);
      running    <= (w_state_nxt == ST_RUN);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_hms.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_hms
// Self-checking bench: two timers (TICK_DIV 1 and 4) against a seconds model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_hms;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] load_sec = 6'd0;
  logic [5:0] load_min = 6'd0;
  logic [4:0] load_hr = 5'd0;

  logic [5:0] sec1, min1, sec4, min4;
  logic [4:0] hr1, hr4;
  logic       bs1, bm1, dn1, ex1, rn1;
  logic       bs4, bm4, dn4, ex4, rn4;
  logic [21:0] obs [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining time as a plain number of seconds per instance
  int m_total [2];
  int m_phase [2];
  int m_mode  [2];
  bit m_bs    [2];
  bit m_bm    [2];
  bit m_dn    [2];

  countdown_timer_hms #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hr(load_hr), .start(start), .pause(pause), .count_sec(sec1),
    .count_min(min1), .count_hr(hr1), .borrow_sec(bs1), .borrow_min(bm1),
    .done(dn1), .expired(ex1), .running(rn1)
  );

  countdown_timer_hms #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hr(load_hr), .start(start), .pause(pause), .count_sec(sec4),
    .count_min(min4), .count_hr(hr4), .borrow_sec(bs4), .borrow_min(bm4),
    .done(dn4), .expired(ex4), .running(rn4)
  );

  assign obs[0] = {hr1, min1, sec1, bs1, bm1, dn1, ex1, rn1};
  assign obs[1] = {hr4, min4, sec4, bs4, bm4, dn4, ex4, rn4};

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [21:0] exp_vec(int k);
    return {5'(m_total[k] / 3600), 6'((m_total[k] / 60) % 60), 6'(m_total[k] % 60),
            m_bs[k], m_bm[k], m_dn[k], (m_mode[k] == M_DONE), (m_mode[k] == M_RUN)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_total[k] = 0; m_phase[k] = 0; m_mode[k] = M_IDLE;
      m_bs[k] = 1'b0; m_bm[k] = 1'b0; m_dn[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    int s, m, h;
    m_bs[k] = 1'b0; m_bm[k] = 1'b0; m_dn[k] = 1'b0;
    if (load) begin
      s = (load_sec > 59) ? 59 : int'(load_sec);
      m = (load_min > 59) ? 59 : int'(load_min);
      h = (load_hr > 23) ? 23 : int'(load_hr);
      m_total[k] = h * 3600 + m * 60 + s;
      m_mode[k]  = M_IDLE;
      m_phase[k] = 0;
    end else begin
      case (m_mode[k])
        M_IDLE:
          if (start && !pause && m_total[k] != 0) begin
            m_mode[k] = M_RUN; m_phase[k] = 0;
          end
        M_RUN:
          if (pause) m_mode[k] = M_PAUSE;
          else if (m_phase[k] == div_of(k) - 1) begin
            m_phase[k] = 0;
            m_bs[k] = (m_total[k] % 60) == 0;
            m_bm[k] = (m_total[k] % 3600) == 0;
            m_total[k] = m_total[k] - 1;
            if (m_total[k] == 0) begin
              m_mode[k] = M_DONE; m_dn[k] = 1'b1;
            end
          end else m_phase[k] = m_phase[k] + 1;
        M_PAUSE:
          if (start && !pause) m_mode[k] = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One clock: step the model on the rising edge, return at the falling edge
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic do_load(int h, int m, int s);
    load = 1'b1; load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 22'd0) begin
        n_fail++; $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs[k], 22'd0);
      end
    end
    #13 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 22'd0) begin
        n_fail++; $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs[k], 22'd0);
      end
    end
  endtask

  task automatic test_expiry();
    do_load(0, 0, 3);
    do_start();
    n_checks++;
    if (sec1 !== 6'd3 || rn1 !== 1'b1) begin
      n_fail++; $display("FAIL expiry_start got sec=%0d run=%b exp sec=3 run=1", sec1, rn1);
    end
    for (int i = 2; i >= 0; i--) begin
      cycle();
      n_checks++;
      if (sec1 !== 6'(i) || dn1 !== (i == 0)) begin
        n_fail++; $display("FAIL expiry_count got sec=%0d done=%b exp sec=%0d done=%b", sec1, dn1, i, (i == 0));
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL expiry_model k=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
        end
      end
    end
    repeat (3) begin
      cycle();
      n_checks++;
      if ({dn1, ex1, rn1} !== 3'b010 || sec1 !== 6'd0) begin
        n_fail++; $display("FAIL expiry_hold got done/exp/run=%b sec=%0d exp 010 sec=0", {dn1, ex1, rn1}, sec1);
      end
    end
  endtask

  task automatic test_borrow_chain();
    do_load(1, 0, 0);
    do_start();
    cycle();
    n_checks++;
    if ({hr1, min1, sec1, bs1, bm1} !== {5'd0, 6'd59, 6'd59, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL borrow_first got %0d:%0d:%0d bs=%b bm=%b exp 0:59:59 bs=1 bm=1", hr1, min1, sec1, bs1, bm1);
    end
    cycle();
    n_checks++;
    if ({hr1, min1, sec1, bs1, bm1} !== {5'd0, 6'd59, 6'd58, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL borrow_second got %0d:%0d:%0d bs=%b bm=%b exp 0:59:58 bs=0 bm=0", hr1, min1, sec1, bs1, bm1);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== exp_vec(k)) begin
        n_fail++; $display("FAIL borrow_model k=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_pause_resume();
    do_load(0, 0, 5);
    do_start();
    repeat (6) begin
      cycle();
      n_checks++;
      if (obs[1] !== exp_vec(1)) begin
        n_fail++; $display("FAIL pause_run_model got=%h exp=%h", obs[1], exp_vec(1));
      end
    end
    n_checks++;
    if (sec4 !== 6'd4) begin
      n_fail++; $display("FAIL pause_pre got sec=%0d exp 4", sec4);
    end
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    repeat (10) begin
      cycle();
      n_checks++;
      if (sec4 !== 6'd4 || rn4 !== 1'b0 || obs[1] !== exp_vec(1)) begin
        n_fail++; $display("FAIL pause_hold got=%h exp=%h (sec 4, not running)", obs[1], exp_vec(1));
      end
    end
    do_start();
    n_checks++;
    if (sec4 !== 6'd4 || rn4 !== 1'b1) begin
      n_fail++; $display("FAIL resume_edge got sec=%0d run=%b exp sec=4 run=1", sec4, rn4);
    end
    cycle();
    n_checks++;
    if (sec4 !== 6'd4) begin
      n_fail++; $display("FAIL resume_plus1 got sec=%0d exp 4", sec4);
    end
    cycle();
    n_checks++;
    if (sec4 !== 6'd3 || obs[1] !== exp_vec(1)) begin
      n_fail++; $display("FAIL resume_plus2 got=%h sec=%0d exp sec=3 model=%h", obs[1], sec4, exp_vec(1));
    end
  endtask

  task automatic test_saturation_zero();
    do_load(30, 60, 63);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k][21:5] !== {5'd23, 6'd59, 6'd59} || obs[k] !== exp_vec(k)) begin
        n_fail++; $display("FAIL saturate k=%0d got=%h exp=%h (23:59:59)", k, obs[k], exp_vec(k));
      end
    end
    do_load(0, 0, 0);
    do_start();
    repeat (3) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== 22'd0) begin
          n_fail++; $display("FAIL zero_start k=%0d got=%h exp=%h", k, obs[k], 22'd0);
        end
      end
    end
  endtask

  task automatic test_priority_done();
    do_load(0, 0, 5);
    do_start();
    cycle();
    load = 1'b1; pause = 1'b1; load_hr = 5'd0; load_min = 6'd10; load_sec = 6'd0;
    cycle();
    load = 1'b0; pause = 1'b0;
    n_checks++;
    if (obs[0] !== {5'd0, 6'd10, 6'd0, 5'b00000}) begin
      n_fail++; $display("FAIL load_pause_tick got=%h exp=%h", obs[0], {5'd0, 6'd10, 6'd0, 5'b00000});
    end
    do_load(0, 0, 2);
    do_start();
    cycle();
    cycle();
    n_checks++;
    if (ex1 !== 1'b1 || dn1 !== 1'b1) begin
      n_fail++; $display("FAIL reach_done got exp=%b done=%b exp 1 1", ex1, dn1);
    end
    start = 1'b1; pause = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b0;
    n_checks++;
    if (obs[0] !== {17'd0, 5'b00010}) begin
      n_fail++; $display("FAIL done_ignore_start got=%h exp=%h", obs[0], {17'd0, 5'b00010});
    end
    do_load(0, 0, 4);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== {5'd0, 6'd0, 6'd4, 5'b00000} || obs[k] !== exp_vec(k)) begin
        n_fail++; $display("FAIL done_load k=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(0, 0, 7);
    do_start();
    cycle();
    cycle();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 22'd0) begin
        n_fail++; $display("FAIL async_clear k=%0d got=%h exp=%h", k, obs[k], 22'd0);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle();
    do_start();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 22'd0 || obs[k] !== exp_vec(k)) begin
        n_fail++; $display("FAIL post_reset_idle k=%0d got=%h exp=%h", k, obs[k], 22'd0);
      end
    end
    do_load(0, 0, 7);
    do_start();
    n_checks++;
    if (sec1 !== 6'd7 || rn1 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_restart got sec=%0d run=%b exp sec=7 run=1", sec1, rn1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom % 12) == 0;
      start    = ($urandom % 4) == 0;
      pause    = ($urandom % 8) == 0;
      load_sec = 6'($urandom % 64);
      load_min = (($urandom % 4) == 0) ? 6'($urandom % 64) : 6'd0;
      load_hr  = (($urandom % 8) == 0) ? 5'($urandom % 32) : 5'd0;
      cycle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL random k=%0d iter=%0d got=%h exp=%h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_expiry();
    test_borrow_chain();
    test_pause_resume();
    test_saturation_zero();
    test_priority_done();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_timer_hms.md
Name: countdown_timer_hms

Overview:
Loadable HH:MM:SS down-counter. It is the counting-down counterpart of the team's free-running 60/60/24 up-counter chain.
- Hours/minutes/seconds fields decrement once per tick, with borrow across fields.
- Start/pause control; signals expiry at 00:00:00.
- Sits beside the clock counter in the timekeeping datapath and feeds the same display/alarm logic.

Parameters:
TICK_DIV, 1, clk cycles per one-second tick (1 = decrement every enabled cycle; must be >= 1)
SEC_MAX, 59, top value of seconds field
MIN_MAX, 59, top value of minutes field
HR_MAX, 23, top value of hours field

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
load  input  1  capture load_hr/load_min/load_sec
load_sec  input  6  seconds preset
load_min  input  6  minutes preset
load_hr  input  5  hours preset
start  input  1  begin/resume countdown
pause  input  1  suspend countdown
count_sec  output  6  current seconds
count_min  output  6  current minutes
count_hr  output  5  current hours
borrow_sec  output  1  1-cycle pulse when seconds wraps 0->SEC_MAX
borrow_min  output  1  1-cycle pulse when minutes wraps 0->MIN_MAX
done  output  1  1-cycle pulse on the cycle count reaches 00:00:00
expired  output  1  level, high while in DONE
running  output  1  level, high while in RUN

Behaviour:
- Reset (rst=0, async):
  - all counts = 0; borrow_sec/borrow_min/done/expired/running = 0
  - state = IDLE; tick divider = 0
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Priority each cycle: load > pause > start.
- load (any state):
  - next state IDLE; fields take preset values; divider cleared
  - each field saturates to its MAX if the preset exceeds it (e.g. load_sec=63 -> 59)
- IDLE + start:
  - count != 0 -> RUN, divider cleared
  - count == 0 -> stay IDLE, no done pulse
- RUN + pause -> PAUSE. Divider and counts hold.
- PAUSE + start -> RUN. Divider resumes from its held value, not cleared.
- DONE: counts hold 0, expired=1. start and pause are ignored; only load or reset leaves DONE.
- Tick: in RUN, divider counts 0..TICK_DIV-1. Tick fires on the cycle the divider equals TICK_DIV-1, then divider wraps to 0. With TICK_DIV=1, tick fires every RUN cycle.
- Decrement on tick (result visible on the next clk edge):
  - sec>0: sec-1
  - sec=0, min>0: sec=SEC_MAX, min-1, borrow_sec=1
  - sec=0, min=0, hr>0: sec=SEC_MAX, min=MIN_MAX, hr-1, borrow_sec=1, borrow_min=1
- Expiry: when a decrement produces 00:00:00, the same edge sets state=DONE, done=1 (one cycle), expired=1, running=0.
- No underflow past zero is possible.
- Pulse rules:
  - borrow_sec, borrow_min and done are high exactly one cycle, aligned with the updated count
  - pulses are never generated outside RUN
- Simultaneous events:
  - pause on a tick cycle: pause wins, no decrement
  - load on a tick cycle: load wins, no decrement, no pulses
- Reset mid-countdown: immediate clear to reset values regardless of clk.

Test Plan:
1. Reset and expiry timing (TICK_DIV=1)
   - Stimulus: hold rst=0 for 15 ns, release; load 00:00:03, start.
   - Required: counts 3,2,1,0 on successive edges; done high exactly on the cycle count=0; expired stays 1; running 0 afterwards.
2. Full borrow chain
   - Stimulus: load 01:00:00, start.
   - Required: first tick gives 00:59:59 with borrow_sec=1 and borrow_min=1 for one cycle; next tick gives 00:59:58 with no borrows.
3. Pause/resume with divider (TICK_DIV=4)
   - Stimulus: load 00:00:05, start; pause after 6 cycles; hold 10 cycles; start.
   - Required: count stays 4 through the pause; next decrement lands 2 cycles after resume (divider preserved).
4. Saturation and zero start
   - Stimulus: load sec=63, min=60, hr=30.
   - Required: count reads 23:59:59.
   - Stimulus: load 00:00:00, start.
   - Required: state stays IDLE; done never pulses; running=0.
5. Priority and exit from DONE
   - Stimulus: in RUN, assert load 00:10:00 and pause together on a tick cycle.
   - Required: count = 00:10:00, IDLE, no pulses.
   - Stimulus: in DONE, assert start.
   - Required: ignored.
   - Stimulus: in DONE, assert load.
   - Required: IDLE with expired=0.
6. Async reset mid-run
   - Stimulus: drop rst between clk edges while counting 00:00:07.
   - Required: all outputs 0 before the next edge; counting does not resume after rst returns high until load+start.
